fft_frame_ctrl: RTL and testbench

Frame sequencer between the NCO sample stream and the FFT wrapper sink. Packs a continuous 14-bit sample stream into N-point Avalon-ST frames (sink_valid/sink_sop/sink_eop) and honours FFT back-pressure, counting any dropped samples. Tracks completion of each transform on the FFT source side. Supports single-shot and continuous capture modes.

---
 rtl/fft_frame_ctrl.sv | 135 +++++++++++++
 tb/tb_fft_frame_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames a continuous sample stream into N-point FFT sink packets
// Handles back-pressure drops, continuous capture and FFT output completion tracking.
module fft_frame_ctrl #(
  parameter int FFT_LEN = 1024,
  parameter int DATA_W  = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cont,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [DATA_W-1:0] sink_real,
  output logic [DATA_W-1:0] sink_imag,
  input  logic              source_valid,
  input  logic              source_eop,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);

  localparam int IDX_W = $clog2(FFT_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FFT_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_WAIT_OUT
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              sink_valid_q, sink_valid_d;
  logic              sink_sop_q, sink_sop_d;
  logic              sink_eop_q, sink_eop_d;
  logic [DATA_W-1:0] sink_real_q, sink_real_d;
  logic              done_q, done_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;

  logic accept;
  logic drop;
  logic last_beat;
  logic src_eop_hs;

  always_comb begin
    accept     = (state_q == ST_STREAM) && in_valid && sink_ready;
    drop       = (state_q == ST_STREAM) && in_valid && !sink_ready;
    last_beat  = (idx_q == IDX_LAST);
    src_eop_hs = source_valid && source_eop;

    state_d      = state_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    sink_valid_d = accept;
    sink_sop_d   = accept && (idx_q == '0);
    sink_eop_d   = accept && last_beat;
    sink_real_d  = accept ? in_data : sink_real_q;
    frame_cnt_d  = src_eop_hs ? frame_cnt_q + 16'd1 : frame_cnt_q;
    drop_cnt_d   = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    overflow_d   = overflow_q || drop;

    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d = ST_STREAM;
          idx_d   = '0;
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (last_beat) begin
            // cont is only looked at here, so a mid-frame change never truncates a frame
            idx_d   = '0;
            state_d = cont ? ST_STREAM : ST_WAIT_OUT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_WAIT_OUT: begin
        if (src_eop_hs) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      sink_valid_q <= 1'b0;
      sink_sop_q   <= 1'b0;
      sink_eop_q   <= 1'b0;
      sink_real_q  <= '0;
      done_q       <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sink_valid_q <= sink_valid_d;
      sink_sop_q   <= sink_sop_d;
      sink_eop_q   <= sink_eop_d;
      sink_real_q  <= sink_real_d;
      done_q       <= done_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign sink_valid = sink_valid_q;
  assign sink_sop   = sink_sop_q;
  assign sink_eop   = sink_eop_q;
  assign sink_real  = sink_real_q;
  assign sink_imag  = '0;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - directed bench for fft_frame_ctrl with FFT_LEN=8
module tb_fft_frame_ctrl;

  localparam int N = 8;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset_n, start, cont, in_valid, sink_ready, source_valid, source_eop;
  logic [W-1:0] in_data;
  logic         sink_valid, sink_sop, sink_eop, busy, done, overflow;
  logic [W-1:0] sink_real, sink_imag;
  logic [15:0]  frame_cnt, drop_cnt;

  fft_frame_ctrl #(.FFT_LEN(N), .DATA_W(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cont(cont),
    .in_data(in_data), .in_valid(in_valid), .sink_ready(sink_ready),
    .sink_valid(sink_valid), .sink_sop(sink_sop), .sink_eop(sink_eop),
    .sink_real(sink_real), .sink_imag(sink_imag),
    .source_valid(source_valid), .source_eop(source_eop),
    .busy(busy), .done(done), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start, cont, iv, rdy, sv, seop;
    logic [W-1:0] data;
    logic         e_valid, e_sop, e_eop, e_busy, e_done;
    logic [W-1:0] e_real;
  } vec_t;

  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  int beat, cyc, first_c, last_c, bad_real;
  int sop_q[$];
  int eop_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    beat = 0; cyc = 0; first_c = -1; last_c = -1; bad_real = 0;
    sop_q.delete();
    eop_q.delete();
  endtask

  // Advance one cycle; log beats and check that each beat carries the sample applied at that edge.
  task automatic mon();
    logic [W-1:0] d;
    d = in_data;
    step();
    cyc++;
    if (sink_valid) begin
      beat++;
      if (first_c < 0) first_c = cyc;
      last_c = cyc;
      if (sink_sop) sop_q.push_back(beat);
      if (sink_eop) eop_q.push_back(beat);
      if (sink_real !== d) bad_real++;
    end
    in_data = in_data + 14'd1;
  endtask

  task automatic src_eop_to_idle(input string tag, input logic [15:0] exp_frames);
    source_valid = 1'b1; source_eop = 1'b1;
    step();
    source_valid = 1'b0; source_eop = 1'b0;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, exp_frames);
    step();
    chk({tag, "_done_falls"}, done, 0);
  endtask

  initial begin
    vecs.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h3FF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h000});
    for (int k = 1; k <= N; k++)
      vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, W'(14'h100 + k),
                       1'b1, (k == 1), (k == N), 1'b1, 1'b0, W'(14'h100 + k)});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 14'h2AA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 14'h108});

    reset_n = 1'b0; start = 1'b0; cont = 1'b0; in_valid = 1'b0; sink_ready = 1'b0;
    source_valid = 1'b0; source_eop = 1'b0; in_data = '0;
    step(); step();
    chk("rst_valid", sink_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_real", sink_real, 0);
    chk("rst_imag", sink_imag, 0);
    chk("rst_counts", {frame_cnt, drop_cnt}, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    step();

    // single-shot frame from the vector table
    for (int i = 0; i < vecs.size(); i++) begin
      start = vecs[i].start; cont = vecs[i].cont; in_valid = vecs[i].iv;
      sink_ready = vecs[i].rdy; source_valid = vecs[i].sv; source_eop = vecs[i].seop;
      in_data = vecs[i].data;
      step();
      chk($sformatf("v%0d_valid", i), sink_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_sop", i), sink_sop, vecs[i].e_sop);
      chk($sformatf("v%0d_eop", i), sink_eop, vecs[i].e_eop);
      chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vecs[i].e_done);
      chk($sformatf("v%0d_real", i), sink_real, vecs[i].e_real);
    end
    start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 19; i++) step();
    chk("t1_wait_busy", busy, 1);
    src_eop_to_idle("t1", 16'd1);
    chk("t1_drop_cnt", drop_cnt, 0);

    // continuous mode, three back-to-back frames
    mon_clear();
    cont = 1'b1; in_valid = 1'b1; sink_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      mon();
      if (beat >= 17) cont = 1'b0;
    end
    chk("t2_beats", beat, 24);
    chk("t2_contiguous", last_c - first_c + 1, 24);
    chk("t2_sops", sop_q.size() == 3 ? {8'(sop_q[0]), 8'(sop_q[1]), 8'(sop_q[2])} : 24'hFFFFFF, {8'd1, 8'd9, 8'd17});
    chk("t2_eops", eop_q.size() == 3 ? {8'(eop_q[0]), 8'(eop_q[1]), 8'(eop_q[2])} : 24'hFFFFFF, {8'd8, 8'd16, 8'd24});
    chk("t2_real", bad_real, 0);
    chk("t2_wait_out", busy, 1);
    src_eop_to_idle("t2", 16'd2);

    // back-pressure drops mid-frame
    mon_clear();
    start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      sink_ready = !(c >= 4 && c <= 6);
      mon();
      start = 1'b0;
    end
    chk("t3_beats", beat, 8);
    chk("t3_eop_beat", eop_q.size() == 1 ? eop_q[0] : -1, 8);
    chk("t3_sop_beat", sop_q.size() == 1 ? sop_q[0] : -1, 1);
    chk("t3_drop_cnt", drop_cnt, 3);
    chk("t3_overflow", overflow, 1);
    chk("t3_real", bad_real, 0);
    sink_ready = 1'b1;
    src_eop_to_idle("t3", 16'd3);

    // in_valid toggling every cycle
    mon_clear();
    in_valid = 1'b0; start = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c % 2 == 1);
      mon();
      start = 1'b0;
    end
    chk("t4_beats", beat, 8);
    chk("t4_span", last_c - first_c, 14);
    chk("t4_eop_beat", eop_q.size() == 1 ? eop_q[0] : -1, 8);
    chk("t4_drop_cnt", drop_cnt, 3);
    in_valid = 1'b0;
    src_eop_to_idle("t4", 16'd4);

    // reset mid-frame after beat 5
    mon_clear();
    start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 20 && beat < 5; c++) begin
      mon();
      start = 1'b0;
    end
    chk("t5_reached_beat5", beat, 5);
    reset_n = 1'b0;
    step();
    chk("t5_rst_valid_eop", {sink_valid, sink_sop, sink_eop}, 0);
    chk("t5_rst_real", sink_real, 0);
    chk("t5_rst_busy_done", {busy, done}, 0);
    chk("t5_rst_counts", {frame_cnt, drop_cnt}, 0);
    chk("t5_rst_overflow", overflow, 0);
    reset_n = 1'b1;
    in_valid = 1'b0;
    step();
    chk("t5_no_stray_valid", sink_valid, 0);
    mon_clear();
    start = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      mon();
      start = 1'b0;
    end
    chk("t5_beats", beat, 8);
    chk("t5_sop_beat", sop_q.size() == 1 ? sop_q[0] : -1, 1);
    chk("t5_eop_beat", eop_q.size() == 1 ? eop_q[0] : -1, 8);

    // drop_cnt saturation and frame_cnt wrap
    reset_n = 1'b0; in_valid = 1'b0;
    step();
    reset_n = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0; in_valid = 1'b1; sink_ready = 1'b0;
    source_valid = 1'b1; source_eop = 1'b1;
    for (int i = 0; i < 65535; i++) step();
    chk("t6_frame_cnt_max", frame_cnt, 16'hFFFF);
    chk("t6_drop_cnt_max", drop_cnt, 16'hFFFF);
    step();
    chk("t6_frame_cnt_wrap", frame_cnt, 16'h0000);
    source_valid = 1'b0; source_eop = 1'b0;
    for (int i = 0; i < 70000 - 65536; i++) step();
    chk("t6_drop_cnt_sat", drop_cnt, 16'hFFFF);
    chk("t6_overflow", overflow, 1);
    chk("t6_busy", busy, 1);
    chk("t6_frame_cnt_hold", frame_cnt, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
